// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM sequencing a shared-memory multicycle MIPS datapath.
// Ports:
//   clk, reset (async, active-low)        clock and reset
//   Opcode, Funct, Zero                   IR fields and ALU zero flag
//   IorD, MemWrite, IRWrite, RegDst,      datapath mux selects and enables
//   MemtoReg, RegWrite, ALUSrcA, ALUSrcB,
//   ALUCtrl, PCSrc, PCEn
//   state, instret, illegal               debug state, retired count, sticky illegal flag
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUCtrl,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);
    localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,
                           S_MEMRD  = 4'd3,  S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,
                           S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,  S_BRANCH = 4'd8,
                           S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR = 3'b001, ALU_SLT = 3'b111;

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q, illegal_set;
    logic             retire;
    logic             funct_ok;
    logic [2:0]       funct_alu;

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (Funct)
            6'd32:   funct_alu = ALU_ADD;
            6'd34:   funct_alu = ALU_SUB;
            6'd36:   funct_alu = ALU_AND;
            6'd37:   funct_alu = ALU_OR;
            6'd42:   funct_alu = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end

    // Leaving any terminal state always returns to FETCH, so that edge retires one instruction.
    assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWR) || (state_q == S_ALUWB) ||
                    (state_q == S_BRANCH) || (state_q == S_ADDIWB) || (state_q == S_JUMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_q + CNT_W'(retire);
            illegal_q <= illegal_q | illegal_set;
        end
    end

    always_comb begin
        state_d     = S_FETCH;
        illegal_set = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      illegal_set = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXEC: begin
                state_d     = S_ALUWB;
                illegal_set = !funct_ok;
            end
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUCtrl  = ALU_ADD;
        PCSrc    = 2'b00;
        PCEn     = 1'b0;
        case (state_q)
            S_FETCH: begin
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCEn    = 1'b1;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUCtrl = funct_alu;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUCtrl = ALU_SUB;
                PCSrc   = 2'b01;
                PCEn    = Zero;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
    end

    assign state   = state_q;
    assign instret = instret_q;
    assign illegal = illegal_q;
endmodule
